// File: rtl/systolic_feeder.sv
// Skewed edge-operand feeder for a 3x3 systolic MAC array (8-bit elements).
// Define SYSTOLIC_FEEDER_ACCUMULATE_EN to skip CLEAR and accumulate across runs.
//
// state | meaning
// IDLE  | waiting for start; operand writes accepted
// CLEAR | one cycle of mac_clr to the array
// FEED  | t=0..4, skewed A rows / B columns presented on the edges
// FLUSH | t=5..6, edges zero while the wavefront drains
// DONE  | one-cycle done pulse
module systolic_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic [7:0] a_row0,
    output logic [7:0] a_row1,
    output logic [7:0] a_row2,
    output logic [7:0] b_col0,
    output logic [7:0] b_col1,
    output logic [7:0] b_col2,
    output logic       mac_en,
    output logic       mac_clr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] t, t_nxt;
    logic [7:0] a_buf [9];
    logic [7:0] b_buf [9];
    logic [7:0] a_fwd [9];
    logic [7:0] b_fwd [9];
    logic [7:0] a_nxt [3];
    logic [7:0] b_nxt [3];
    logic       wr_ok;
    logic       en_nxt, clr_nxt, busy_nxt, done_nxt;

    assign wr_ok = wr_en && (state == IDLE) && (wr_addr <= 4'd8);

    // Buffer view including this cycle's write, so a same-cycle start sees it.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            a_fwd[k] = a_buf[k];
            b_fwd[k] = b_buf[k];
            if (wr_ok && wr_addr == 4'(k)) begin
                if (wr_sel) b_fwd[k] = wr_data;
                else        a_fwd[k] = wr_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (start) begin
                    t_nxt = 3'd0;
`ifdef SYSTOLIC_FEEDER_ACCUMULATE_EN
                    state_nxt = FEED;
`else
                    state_nxt = CLEAR;
`endif
                end
            end
            CLEAR: begin
                state_nxt = FEED;
                t_nxt     = 3'd0;
            end
            FEED: begin
                t_nxt = t + 3'd1;
                if (t == 3'd4) state_nxt = FLUSH;
            end
            FLUSH: begin
                t_nxt = t + 3'd1;
                if (t == 3'd6) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        en_nxt   = (state_nxt == FEED) || (state_nxt == FLUSH);
        clr_nxt  = (state_nxt == CLEAR);
        done_nxt = (state_nxt == DONE);
        for (int i = 0; i < 3; i++) begin
            a_nxt[i] = 8'd0;
            b_nxt[i] = 8'd0;
        end
        if (state_nxt == FEED) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (t_nxt == 3'(i + k)) begin
                        a_nxt[i] = a_fwd[i*3 + k];
                        b_nxt[i] = b_fwd[k*3 + i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            t       <= 3'd0;
            a_row0  <= 8'd0;
            a_row1  <= 8'd0;
            a_row2  <= 8'd0;
            b_col0  <= 8'd0;
            b_col1  <= 8'd0;
            b_col2  <= 8'd0;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                a_buf[k] <= 8'd0;
                b_buf[k] <= 8'd0;
            end
        end else begin
            state   <= state_nxt;
            t       <= t_nxt;
            a_row0  <= a_nxt[0];
            a_row1  <= a_nxt[1];
            a_row2  <= a_nxt[2];
            b_col0  <= b_nxt[0];
            b_col1  <= b_nxt[1];
            b_col2  <= b_nxt[2];
            mac_en  <= en_nxt;
            mac_clr <= clr_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            for (int k = 0; k < 9; k++) begin
                a_buf[k] <= a_fwd[k];
                b_buf[k] <= b_fwd[k];
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: systolic_feeder driving a behavioural 3x3 MAC grid.
module tb_systolic_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start = 1'b0;
    logic [7:0] a_row0, a_row1, a_row2, b_col0, b_col1, b_col2;
    logic       mac_en, mac_clr, busy, done;

    int total = 0;
    int bad = 0;

`ifdef SYSTOLIC_FEEDER_ACCUMULATE_EN
    localparam int LAT = 8;
    localparam int FEED_OFS = 1;
    localparam int ACC_K = 2;
`else
    localparam int LAT = 9;
    localparam int FEED_OFS = 2;
    localparam int ACC_K = 1;
`endif

    always #5 clk = ~clk;

    systolic_feeder dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .a_row0(a_row0), .a_row1(a_row1), .a_row2(a_row2),
        .b_col0(b_col0), .b_col1(b_col1), .b_col2(b_col2),
        .mac_en(mac_en), .mac_clr(mac_clr), .busy(busy), .done(done)
    );

    // Output-stationary MAC grid: A flows right, B flows down.
    logic [7:0] ar [3][3];
    logic [7:0] br [3][3];
    logic [7:0] acc [3][3];
    logic [7:0] ain [3][3];
    logic [7:0] bin [3][3];
    logic [7:0] a_edge [3];
    logic [7:0] b_edge [3];

    assign a_edge[0] = a_row0;
    assign a_edge[1] = a_row1;
    assign a_edge[2] = a_row2;
    assign b_edge[0] = b_col0;
    assign b_edge[1] = b_col1;
    assign b_edge[2] = b_col2;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ain[i][j] = (j == 0) ? a_edge[i] : ar[i][j-1];
                bin[i][j] = (i == 0) ? b_edge[j] : br[i-1][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (reset || mac_clr) begin
                    ar[i][j]  <= 8'd0;
                    br[i][j]  <= 8'd0;
                    acc[i][j] <= 8'd0;
                end else if (mac_en) begin
                    ar[i][j]  <= ain[i][j];
                    br[i][j]  <= bin[i][j];
                    acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [7:0] ma [9], input logic [7:0] mb [9]);
        for (int k = 0; k < 9; k++) wr(1'b0, 4'(k), ma[k]);
        for (int k = 0; k < 9; k++) wr(1'b1, 4'(k), mb[k]);
    endtask

    task automatic check_cells(input string tag, input logic [7:0] exp [9]);
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s_c%0d%0d", tag, k / 3, k % 3), 32'(acc[k/3][k%3]), 32'(exp[k]));
    endtask

    int         lat;
    int         ndone;
    logic [7:0] a2_at [5];
    logic [7:0] a0_at [5];

    // Start a run and watch 20 cycles. spur_t: FEED t at which start is pulsed
    // again; badwr_t: FEED t at which a write is attempted; cw_*: write in the start cycle.
    task automatic run(input int spur_t, input int badwr_t, input logic cw_en,
                       input logic [3:0] cw_addr, input logic [7:0] cw_data);
        start = 1'b1;
        wr_en = cw_en; wr_sel = 1'b0; wr_addr = cw_addr; wr_data = cw_data;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        lat = -1;
        ndone = 0;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (n - FEED_OFS >= 0 && n - FEED_OFS <= 4) begin
                a2_at[n - FEED_OFS] = a_row2;
                a0_at[n - FEED_OFS] = a_row0;
            end
            start = (n == FEED_OFS + spur_t);
            if (n == FEED_OFS + badwr_t) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd9;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    logic [7:0] m_id [9] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    logic [7:0] m_19 [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    logic [7:0] m_2  [9] = '{default: 8'd2};
    logic [7:0] m_3  [9] = '{default: 8'd3};
    logic [7:0] m_18 [9] = '{default: 8'd18};
    logic [7:0] m_0  [9] = '{default: 8'd0};
    logic [7:0] m_a7 [9] = '{8'h7F, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] m_b2 [9] = '{8'h02, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] m_fe [9] = '{8'hFE, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] m_c5 [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] m_19k [9];

    initial begin
        for (int k = 0; k < 9; k++) m_19k[k] = 8'(ACC_K * (k + 1));

        // Reset state
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd0);
        chk("rst_edges", 32'({a_row0, a_row1, a_row2} | {b_col0, b_col1, b_col2}), 32'd0);

        // Identity x 1..9, with out-of-range writes that must not alias
        load(m_id, m_19);
        for (int k = 9; k < 16; k++) wr(1'b0, 4'(k), 8'h55);
        run(-10, -10, 1'b0, 4'd0, 8'd0);
        chk("id_latency", 32'(lat), 32'(LAT));
        chk("id_ndone", 32'(ndone), 32'd1);
        check_cells("id", m_19);
        // Second run with a write attempted mid-run (must be ignored)
        run(-10, 1, 1'b0, 4'd0, 8'd0);
        chk("id2_ndone", 32'(ndone), 32'd1);
        check_cells("id2", m_19k);

        // All 2 x all 3, plus skew check on a_row2
        do_reset();
        load(m_2, m_3);
        run(-10, -10, 1'b0, 4'd0, 8'd0);
        chk("a2_t1", 32'(a2_at[1]), 32'd0);
        chk("a2_t2", 32'(a2_at[2]), 32'd2);
        chk("a0_t0", 32'(a0_at[0]), 32'd2);
        chk("a0_t3", 32'(a0_at[3]), 32'd0);
        check_cells("all", m_18);

        // 0x7F * 2 wraps to 0xFE in cell (0,0)
        do_reset();
        load(m_a7, m_b2);
        run(-10, -10, 1'b0, 4'd0, 8'd0);
        check_cells("wrap", m_fe);

        // Write A[1][1]=5 in the start cycle; spurious start at FEED t=2
        do_reset();
        load(m_0, m_id);
        run(2, -10, 1'b1, 4'd4, 8'd5);
        chk("same_ndone", 32'(ndone), 32'd1);
        chk("same_latency", 32'(lat), 32'(LAT));
        check_cells("same", m_c5);

        // Reset at FEED t=3 aborts the run
        do_reset();
        load(m_id, m_19);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < FEED_OFS + 3; n++) tick();
        chk("abort_mac_en_before", 32'(mac_en), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mac_en", 32'(mac_en), 32'd0);
        chk("abort_edges", 32'({a_row0, a_row1, a_row2} | {b_col0, b_col1, b_col2}), 32'd0);
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort_ndone", 32'(ndone), 32'd0);
        load(m_id, m_19);
        run(-10, -10, 1'b0, 4'd0, 8'd0);
        chk("rerun_latency", 32'(lat), 32'(LAT));
        check_cells("rerun", m_19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
